decode_stage_pipe: RTL and testbench
====================================

# decode_stage_pipe

Pipelined successor to the single-cycle decode stage. It accepts instructions from fetch over a valid/ready handshake, reads a parametrised register file, and generates the immediate for every RV32I format (I/S/B/U/J). It registers the decoded bundle into an ID/EX pipeline register. A load-use interlock, flush, and backpressure let it sit between the fetch and execute stages of the pipelined core.

## Interface
- XLEN, 32: datapath width; immediates sign-extend to XLEN.
- NREG, 32: architectural register count, 16 (RV32E) or 32.
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage accepts this cycle.
- instruction  in  32  raw instruction word.
- pc  in  XLEN  instruction address.
- flush  in  1  kill the held and incoming instruction.
- wb_en  in  1  register write enable.
- wb_rd  in  5  write index.
- wb_value  in  XLEN  write data.
- out_valid  out  1  ID/EX register holds a valid instruction.
- out_ready  in  1  execute consumes this cycle.
- out_opcode  out  7, out_fn3  out  3, out_fn7  out  7: decoded fields.
- out_rs1, out_rs2, out_rd  out  5 each: register indices.
- out_rs1_value, out_rs2_value  out  XLEN: register operands.
- out_imm  out  XLEN: sign-extended immediate.
- out_pc  out  XLEN: instruction address.
- out_alu_source  out  1: 1 selects imm as the second ALU operand.
- out_illegal  out  1: unknown opcode, or a register index ≥ NREG.

## Operation
- Field slicing: opcode [6:0], rd [11:7], fn3 [14:12], rs1 [19:15], rs2 [24:20], fn7 [31:25].
- Immediate format by opcode:
  - I: 0010011, 0000011, 1100111, 1110011.
  - S: 0100011.
  - B: 1100011.
  - U: 0110111, 0010111.
  - J: 1101111.
  - R: 0110011, imm=0.
  - Any other opcode: imm=0, illegal=1.
  - Sign bit is always instruction[31]. U places [31:12] in the top bits with zero low bits. B and J have bit 0 = 0.
- alu_source=1 for I/S/U/J, 0 for R/B.
- rs1 is used by I/S/B/R; rs2 by S/B/R.
- Register file: NREG×XLEN, 2 read ports, 1 write port.
  - Read is combinational.
  - Write at posedge when wb_en, wb_rd≠0 and wb_rd<NREG. Otherwise the write is ignored.
  - x0 always reads 0.
  - An out-of-range read index returns 0.
- Load-use hazard: out_valid, held opcode=0000011, held rd≠0, and the incoming instruction uses rs1 or rs2 equal to held rd.
- in_ready = !reset && !hazard && (!out_valid || out_ready).
- ID/EX register update at each posedge, in priority order:
  1. flush: out_valid←0; the incoming instruction is dropped even if the handshake fired.
  2. in_valid && in_ready: load all out_* fields, out_valid←1.
  3. out_ready with no load: out_valid←0. This is the bubble inserted on a hazard.
  4. Otherwise: hold.
- Held operand values are captured at load time and are not refreshed by later writebacks. Execute-stage forwarding covers that case.

## Timing
- Reset (async): out_valid=0, every out_* field=0, all registers=0, in_ready=0.
- Decode latency: 1 cycle from the accepted handshake to out_valid.
- Throughput: 1 instruction per cycle with out_ready held high.
- Hazard: exactly one bubble. The dependent instruction is accepted in the cycle after the load drains.
- Simultaneous flush and a handshake: flush wins, and fetch sees the instruction as consumed.
- Reset asserted mid-stall: the held instruction is lost; in_ready deasserts immediately.
- Simultaneous WB write and read of the same index: see Configuration.

## Configuration
- DECODE_WB_BYPASS_EN defined:
  - A read port whose index equals wb_rd while a qualifying write occurs returns wb_value in the same cycle.
  - x0 is still 0.
- DECODE_WB_BYPASS_EN undefined: the read returns the old value. The new value is visible from the next cycle.

## Structure
- decode_pkg:
  - Opcode constants.
  - imm_fmt_e enum (I, S, B, U, J, R, NONE).
  - decoded_t struct bundling all out_* fields.
  - Immediate-generation function.
- Sub-module decode_regfile: parameters XLEN and NREG; contains the bypass logic; async reset clears all entries.

## Test plan
- Reset, then addi x1,x0,-5 (0xFFB00093) with out_ready=1 → next cycle out_valid=1, imm=0xFFFFFFFB, alu_source=1, rd=1, illegal=0.
- WB x2=0x1234 one cycle, then add x3,x2,x2 → rs1_value=rs2_value=0x1234. With bypass, presenting WB and the add in the same cycle gives the same result; without bypass it gives 0.
- lw x5,0(x1) followed by add x6,x5,x0 → in_ready=0 for one cycle, one bubble (out_valid=0), then the add appears.
- out_ready=0 for 3 cycles with a stream of instructions → held bundle unchanged, in_ready=0, no instruction lost or duplicated.
- flush coincident with an accepted beq → out_valid=0 next cycle, the beq is never presented.
- NREG=16, instruction using x20 → illegal=1, operand=0; wb_rd=20 write is ignored.

Source files
------------

// File: rtl/decode_pkg.sv
// decode_pkg: opcode constants, immediate format enum, decoded control bundle, decode helpers.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
// Ports: none (package).
package decode_pkg;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic [2:0] {
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_R,
    FMT_NONE
  } imm_fmt_e;

  // XLEN-independent part of the ID/EX bundle; the XLEN-wide operands,
  // immediate and pc are wrapped around this in the stage itself.
  typedef struct packed {
    logic [6:0] opcode;
    logic [2:0] fn3;
    logic [6:0] fn7;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       alu_source;
    logic       illegal;
  } decoded_t;

  function automatic imm_fmt_e imm_fmt(input logic [6:0] opcode);
    imm_fmt_e fmt;
    case (opcode)
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: fmt = FMT_I;
      OP_STORE:                            fmt = FMT_S;
      OP_BRANCH:                           fmt = FMT_B;
      OP_LUI, OP_AUIPC:                    fmt = FMT_U;
      OP_JAL:                              fmt = FMT_J;
      OP_REG:                              fmt = FMT_R;
      default:                             fmt = FMT_NONE;
    endcase
    return fmt;
  endfunction

  // 32-bit immediate; instr[31] is the sign bit for every format.
  function automatic logic [31:0] gen_imm(input logic [31:0] instr, input imm_fmt_e fmt);
    logic [31:0] imm;
    case (fmt)
      FMT_I:   imm = {{21{instr[31]}}, instr[30:20]};
      FMT_S:   imm = {{21{instr[31]}}, instr[30:25], instr[11:7]};
      FMT_B:   imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U:   imm = {instr[31:12], 12'b0};
      FMT_J:   imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

  function automatic logic uses_rs1(input imm_fmt_e fmt);
    return (fmt == FMT_I) || (fmt == FMT_S) || (fmt == FMT_B) || (fmt == FMT_R);
  endfunction

  function automatic logic uses_rs2(input imm_fmt_e fmt);
    return (fmt == FMT_S) || (fmt == FMT_B) || (fmt == FMT_R);
  endfunction

  function automatic logic writes_rd(input imm_fmt_e fmt);
    return (fmt == FMT_I) || (fmt == FMT_U) || (fmt == FMT_J) || (fmt == FMT_R);
  endfunction

  function automatic logic uses_imm(input imm_fmt_e fmt);
    return (fmt == FMT_I) || (fmt == FMT_S) || (fmt == FMT_U) || (fmt == FMT_J);
  endfunction

endpackage

// File: rtl/decode_regfile.sv
// decode_regfile: NREG x XLEN register file, 2 combinational read ports, 1 write port.
// Latency: reads combinational; a write is visible from the cycle after its posedge.
// Backpressure: none; writes to x0 or to an index >= NREG are dropped.
// Optional: DECODE_WB_BYPASS_EN returns a same-cycle qualifying write on a matching read port.
// Ports: i_clk, i_reset (async, active-high, clears all entries); i_wb_en/i_wb_rd/i_wb_value write;
//        i_rs1/i_rs2 read indices; o_rs1_value/o_rs2_value read data (0 for x0 or out-of-range).
module decode_regfile
  import decode_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_wb_en,
  input  logic [4:0]      i_wb_rd,
  input  logic [XLEN-1:0] i_wb_value,
  input  logic [4:0]      i_rs1,
  input  logic [4:0]      i_rs2,
  output logic [XLEN-1:0] o_rs1_value,
  output logic [XLEN-1:0] o_rs2_value
);

  localparam int         IW     = (NREG > 1) ? $clog2(NREG) : 1;
  localparam logic [5:0] NREG_L = 6'(NREG);

  logic [XLEN-1:0] r_regs [NREG];
  logic            w_wr_en;

  assign w_wr_en = i_wb_en && (i_wb_rd != 5'd0) && ({1'b0, i_wb_rd} < NREG_L);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_regs[i_wb_rd[IW-1:0]] <= i_wb_value;
    end
  end

  always_comb begin
    o_rs1_value = '0;
    o_rs2_value = '0;
    if ((i_rs1 != 5'd0) && ({1'b0, i_rs1} < NREG_L)) begin
      o_rs1_value = r_regs[i_rs1[IW-1:0]];
    end
    if ((i_rs2 != 5'd0) && ({1'b0, i_rs2} < NREG_L)) begin
      o_rs2_value = r_regs[i_rs2[IW-1:0]];
    end
`ifdef DECODE_WB_BYPASS_EN
    // w_wr_en already excludes x0 and out-of-range indices, so those still read 0.
    if (w_wr_en && (i_rs1 == i_wb_rd)) begin
      o_rs1_value = i_wb_value;
    end
    if (w_wr_en && (i_rs2 == i_wb_rd)) begin
      o_rs2_value = i_wb_value;
    end
`else
    // Without the bypass a same-cycle write is seen from the next cycle.
`endif
  end

endmodule

// File: rtl/decode_stage_pipe.sv
// decode_stage_pipe: RV32I decode stage with register read, immediate generation and ID/EX register.
// Latency: 1 cycle from accepted handshake to o_out_valid; 1 instruction/cycle with i_out_ready high.
// Backpressure: o_in_ready low in reset, on a load-use hazard, or while a held bundle is not consumed.
// Optional: DECODE_WB_BYPASS_EN (in decode_regfile) forwards a same-cycle writeback to the reads.
// Ports: i_in_valid/o_in_ready/i_instruction/i_pc from fetch; i_flush kills held and incoming;
//        i_wb_* register writeback; o_out_valid/i_out_ready and o_out_* decoded bundle to execute.
module decode_stage_pipe
  import decode_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_in_valid,
  output logic            o_in_ready,
  input  logic [31:0]     i_instruction,
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_flush,
  input  logic            i_wb_en,
  input  logic [4:0]      i_wb_rd,
  input  logic [XLEN-1:0] i_wb_value,
  output logic            o_out_valid,
  input  logic            i_out_ready,
  output logic [6:0]      o_out_opcode,
  output logic [2:0]      o_out_fn3,
  output logic [6:0]      o_out_fn7,
  output logic [4:0]      o_out_rs1,
  output logic [4:0]      o_out_rs2,
  output logic [4:0]      o_out_rd,
  output logic [XLEN-1:0] o_out_rs1_value,
  output logic [XLEN-1:0] o_out_rs2_value,
  output logic [XLEN-1:0] o_out_imm,
  output logic [XLEN-1:0] o_out_pc,
  output logic            o_out_alu_source,
  output logic            o_out_illegal
);

  typedef struct packed {
    decoded_t        ctrl;
    logic [XLEN-1:0] rs1_value;
    logic [XLEN-1:0] rs2_value;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
  } idex_t;

  localparam logic [5:0] NREG_L = 6'(NREG);

  logic            r_valid;
  idex_t           r_idex;
  idex_t           w_next;
  imm_fmt_e        w_fmt;
  logic [31:0]     w_imm32;
  logic [XLEN-1:0] w_rs1_value;
  logic [XLEN-1:0] w_rs2_value;
  logic            w_idx_bad;
  logic            w_hazard;
  logic            w_accept;

  decode_regfile #(
    .XLEN (XLEN),
    .NREG (NREG)
  ) u_regfile (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_wb_en     (i_wb_en),
    .i_wb_rd     (i_wb_rd),
    .i_wb_value  (i_wb_value),
    .i_rs1       (i_instruction[19:15]),
    .i_rs2       (i_instruction[24:20]),
    .o_rs1_value (w_rs1_value),
    .o_rs2_value (w_rs2_value)
  );

  always_comb begin
    w_fmt   = imm_fmt(i_instruction[6:0]);
    w_imm32 = gen_imm(i_instruction, w_fmt);

    // Only indices the format actually uses can make the instruction illegal.
    w_idx_bad = (uses_rs1(w_fmt)  && ({1'b0, i_instruction[19:15]} >= NREG_L)) ||
                (uses_rs2(w_fmt)  && ({1'b0, i_instruction[24:20]} >= NREG_L)) ||
                (writes_rd(w_fmt) && ({1'b0, i_instruction[11:7]}  >= NREG_L));

    w_next.ctrl.opcode     = i_instruction[6:0];
    w_next.ctrl.fn3        = i_instruction[14:12];
    w_next.ctrl.fn7        = i_instruction[31:25];
    w_next.ctrl.rs1        = i_instruction[19:15];
    w_next.ctrl.rs2        = i_instruction[24:20];
    w_next.ctrl.rd         = i_instruction[11:7];
    w_next.ctrl.alu_source = uses_imm(w_fmt);
    w_next.ctrl.illegal    = (w_fmt == FMT_NONE) || w_idx_bad;
    w_next.rs1_value       = w_rs1_value;
    w_next.rs2_value       = w_rs2_value;
    w_next.imm             = XLEN'(signed'(w_imm32));
    w_next.pc              = i_pc;
  end

  // A load still in ID/EX cannot forward its data yet, so a dependent
  // instruction waits one cycle; the load drains and leaves a bubble.
  assign w_hazard = r_valid && (r_idex.ctrl.opcode == OP_LOAD) && (r_idex.ctrl.rd != 5'd0) &&
                    ((uses_rs1(w_fmt) && (i_instruction[19:15] == r_idex.ctrl.rd)) ||
                     (uses_rs2(w_fmt) && (i_instruction[24:20] == r_idex.ctrl.rd)));

  assign o_in_ready = !i_reset && !w_hazard && (!r_valid || i_out_ready);
  assign w_accept   = i_in_valid && o_in_ready;

  // Flush overrides a handshake that fired in the same cycle: fetch still
  // sees it consumed, but the instruction is dropped here.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_valid <= 1'b0;
      r_idex  <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_idex  <= w_next;
    end else if (i_out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_out_valid      = r_valid;
  assign o_out_opcode     = r_idex.ctrl.opcode;
  assign o_out_fn3        = r_idex.ctrl.fn3;
  assign o_out_fn7        = r_idex.ctrl.fn7;
  assign o_out_rs1        = r_idex.ctrl.rs1;
  assign o_out_rs2        = r_idex.ctrl.rs2;
  assign o_out_rd         = r_idex.ctrl.rd;
  assign o_out_rs1_value  = r_idex.rs1_value;
  assign o_out_rs2_value  = r_idex.rs2_value;
  assign o_out_imm        = r_idex.imm;
  assign o_out_pc         = r_idex.pc;
  assign o_out_alu_source = r_idex.ctrl.alu_source;
  assign o_out_illegal    = r_idex.ctrl.illegal;

endmodule

// File: tb/tb_decode_stage_pipe.sv
module tb_decode_stage_pipe;

  localparam int F_I = 0, F_S = 1, F_B = 2, F_U = 3, F_J = 4, F_R = 5, F_X = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, in_ready, flush, wb_en, out_ready, out_valid;
  logic [31:0] instr, pc, wb_value;
  logic [4:0]  wb_rd;
  logic [6:0]  out_opcode, out_fn7;
  logic [2:0]  out_fn3;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [31:0] out_rs1_value, out_rs2_value, out_imm, out_pc;
  logic        out_alu_source, out_illegal;

  logic        n_in_valid, n_in_ready, n_flush, n_wb_en, n_out_ready, n_out_valid;
  logic [31:0] n_instr, n_pc, n_wb_value;
  logic [4:0]  n_wb_rd;
  logic [6:0]  n_opcode, n_fn7;
  logic [2:0]  n_fn3;
  logic [4:0]  n_rs1, n_rs2, n_rd;
  logic [31:0] n_rs1_value, n_rs2_value, n_imm, n_pc_out;
  logic        n_alu_source, n_illegal;

  int ntests = 0;
  int nfail  = 0;

  decode_stage_pipe #(.XLEN(32), .NREG(32)) dut (
    .i_clk(clk), .i_reset(rst), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_instruction(instr), .i_pc(pc), .i_flush(flush), .i_wb_en(wb_en),
    .i_wb_rd(wb_rd), .i_wb_value(wb_value), .o_out_valid(out_valid),
    .i_out_ready(out_ready), .o_out_opcode(out_opcode), .o_out_fn3(out_fn3),
    .o_out_fn7(out_fn7), .o_out_rs1(out_rs1), .o_out_rs2(out_rs2), .o_out_rd(out_rd),
    .o_out_rs1_value(out_rs1_value), .o_out_rs2_value(out_rs2_value),
    .o_out_imm(out_imm), .o_out_pc(out_pc), .o_out_alu_source(out_alu_source),
    .o_out_illegal(out_illegal)
  );

  decode_stage_pipe #(.XLEN(32), .NREG(16)) dut16 (
    .i_clk(clk), .i_reset(rst), .i_in_valid(n_in_valid), .o_in_ready(n_in_ready),
    .i_instruction(n_instr), .i_pc(n_pc), .i_flush(n_flush), .i_wb_en(n_wb_en),
    .i_wb_rd(n_wb_rd), .i_wb_value(n_wb_value), .o_out_valid(n_out_valid),
    .i_out_ready(n_out_ready), .o_out_opcode(n_opcode), .o_out_fn3(n_fn3),
    .o_out_fn7(n_fn7), .o_out_rs1(n_rs1), .o_out_rs2(n_rs2), .o_out_rd(n_rd),
    .o_out_rs1_value(n_rs1_value), .o_out_rs2_value(n_rs2_value),
    .o_out_imm(n_imm), .o_out_pc(n_pc_out), .o_out_alu_source(n_alu_source),
    .o_out_illegal(n_illegal)
  );

  // ---------------- reference model (32 registers) ----------------
  logic        m_valid;
  logic [31:0] m_ins, m_pc, m_v1, m_v2;
  logic [31:0] m_regs [32];
  logic [6:0]  ops [12] = '{7'h13, 7'h03, 7'h03, 7'h67, 7'h73, 7'h23,
                            7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h7F};

  function automatic int m_fmt(input logic [31:0] ins);
    case (ins & 32'h7F)
      32'h13, 32'h03, 32'h67, 32'h73: return F_I;
      32'h23:                         return F_S;
      32'h63:                         return F_B;
      32'h37, 32'h17:                 return F_U;
      32'h6F:                         return F_J;
      32'h33:                         return F_R;
      default:                        return F_X;
    endcase
  endfunction

  function automatic logic [31:0] m_imm(input logic [31:0] ins);
    int s, f;
    s = ((ins >> 31) != 0) ? -1 : 0;
    f = m_fmt(ins);
    case (f)
      F_I: return 32'(s * 2048 + int'((ins >> 20) & 2047));
      F_S: return 32'(s * 2048 + int'((ins >> 25) & 63) * 32 + int'((ins >> 7) & 31));
      F_B: return 32'(s * 4096 + int'((ins >> 7) & 1) * 2048 + int'((ins >> 25) & 63) * 32
                      + int'((ins >> 8) & 15) * 2);
      F_U: return ins & 32'hFFFFF000;
      F_J: return 32'(s * 1048576 + int'((ins >> 12) & 255) * 4096 + int'((ins >> 20) & 1) * 2048
                      + int'((ins >> 21) & 1023) * 2);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic m_u1(input logic [31:0] ins);
    int f;
    f = m_fmt(ins);
    return (f == F_I) || (f == F_S) || (f == F_B) || (f == F_R);
  endfunction

  function automatic logic m_u2(input logic [31:0] ins);
    int f;
    f = m_fmt(ins);
    return (f == F_S) || (f == F_B) || (f == F_R);
  endfunction

  function automatic logic [31:0] m_read(input int idx);
    if (idx == 0 || idx >= 32) return 32'd0;
`ifdef DECODE_WB_BYPASS_EN
    if (wb_en && int'(wb_rd) == idx) return wb_value;
`endif
    return m_regs[idx];
  endfunction

  function automatic logic m_hazard(input logic [31:0] ins);
    int hrd;
    hrd = int'((m_ins >> 7) & 31);
    if (!m_valid || (m_ins & 32'h7F) != 32'h03 || hrd == 0) return 1'b0;
    return (m_u1(ins) && int'((ins >> 15) & 31) == hrd) ||
           (m_u2(ins) && int'((ins >> 20) & 31) == hrd);
  endfunction

  task automatic m_reset();
    m_valid = 1'b0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_out();
    int f;
    chk("out_valid", out_valid, m_valid);
    if (m_valid) begin
      f = m_fmt(m_ins);
      chk("fields", {out_opcode, out_fn3, out_fn7, out_rs1, out_rs2, out_rd},
          {m_ins[6:0], m_ins[14:12], m_ins[31:25], m_ins[19:15], m_ins[24:20], m_ins[11:7]});
      chk("rs1_value", out_rs1_value, m_v1);
      chk("rs2_value", out_rs2_value, m_v2);
      chk("imm", out_imm, m_imm(m_ins));
      chk("pc", out_pc, m_pc);
      chk("alu_source", out_alu_source, (f == F_I) || (f == F_S) || (f == F_U) || (f == F_J));
      chk("illegal", out_illegal, f == F_X);
    end
  endtask

  // One clock: inputs are already driven; check in_ready, step model, check outputs.
  task automatic cycle(output logic rdy_seen);
    logic        rdy, acc;
    logic [31:0] v1, v2;
    #1;
    rdy      = !m_hazard(instr) && (!m_valid || out_ready);
    rdy_seen = in_ready;
    chk("in_ready", in_ready, rdy);
    acc = in_valid && rdy;
    v1  = m_read(int'((instr >> 15) & 31));
    v2  = m_read(int'((instr >> 20) & 31));
    @(posedge clk);
    if (flush) m_valid = 1'b0;
    else if (acc) begin
      m_valid = 1'b1; m_ins = instr; m_pc = pc; m_v1 = v1; m_v2 = v2;
    end else if (out_ready) m_valid = 1'b0;
    if (wb_en && wb_rd != 5'd0) m_regs[wb_rd] = wb_value;
    #1;
    check_out();
  endtask

  task automatic put(input logic v, input logic [31:0] ins, input logic ordy);
    in_valid  = v;
    instr     = ins;
    pc        = pc + 32'd4;
    out_ready = ordy;
    flush     = 1'b0;
    wb_en     = 1'b0;
  endtask

  initial begin
    logic        r;
    logic [31:0] hold_pc, exp_byp;

    rst = 1'b1; in_valid = 1'b1; instr = 32'hFFB00093; pc = 32'h1000; flush = 1'b0;
    wb_en = 1'b0; wb_rd = '0; wb_value = '0; out_ready = 1'b1;
    n_in_valid = 1'b0; n_instr = '0; n_pc = 32'h2000; n_flush = 1'b0; n_wb_en = 1'b0;
    n_wb_rd = '0; n_wb_value = '0; n_out_ready = 1'b1;
    m_reset();

    // Reset state
    #2;
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_ctrl", {out_opcode, out_fn3, out_fn7, out_rs1, out_rs2, out_rd,
                     out_alu_source, out_illegal}, 64'd0);
    chk("rst_vals", {out_rs1_value, out_rs2_value}, 64'd0);
    chk("rst_imm_pc", {out_imm, out_pc}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_valid", out_valid, 1'b0);
    rst = 1'b0;

    // addi x1,x0,-5
    put(1'b1, 32'hFFB00093, 1'b1); cycle(r);
    chk("addi_valid", out_valid, 1'b1);
    chk("addi_imm", out_imm, 32'hFFFFFFFB);
    chk("addi_alu", out_alu_source, 1'b1);
    chk("addi_rd", out_rd, 5'd1);
    chk("addi_illegal", out_illegal, 1'b0);

    // WB x2 then add x3,x2,x2
    put(1'b0, 32'h0, 1'b1); wb_en = 1'b1; wb_rd = 5'd2; wb_value = 32'h1234; cycle(r);
    put(1'b1, 32'h002101B3, 1'b1); cycle(r);
    chk("wb_rs1", out_rs1_value, 32'h1234);
    chk("wb_rs2", out_rs2_value, 32'h1234);

    // Same-cycle WB x4 and add x7,x4,x4
    put(1'b1, 32'h004203B3, 1'b1); wb_en = 1'b1; wb_rd = 5'd4; wb_value = 32'hABCD; cycle(r);
`ifdef DECODE_WB_BYPASS_EN
    exp_byp = 32'hABCD;
`else
    exp_byp = 32'h0;
`endif
    chk("same_cycle_rs1", out_rs1_value, exp_byp);
    chk("same_cycle_rs2", out_rs2_value, exp_byp);
    put(1'b1, 32'h004203B3, 1'b1); cycle(r);
    chk("next_cycle_rs1", out_rs1_value, 32'hABCD);

    // lw x5,0(x1) then add x6,x5,x0: one stall, one bubble
    put(1'b1, 32'h0000A283, 1'b1); cycle(r);
    chk("lw_opcode", out_opcode, 7'h03);
    put(1'b1, 32'h00028333, 1'b1); cycle(r);
    chk("hazard_stall", r, 1'b0);
    chk("hazard_bubble", out_valid, 1'b0);
    cycle(r);
    chk("hazard_accept", r, 1'b1);
    chk("hazard_add_rd", {out_valid, out_rd}, {1'b1, 5'd6});

    // Backpressure: held bundle stays put for 3 cycles
    put(1'b1, 32'h00100413, 1'b1); cycle(r);
    hold_pc = pc;
    put(1'b1, 32'h00200493, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(r);
      chk("stall_ready", r, 1'b0);
      chk("stall_hold", {out_valid, out_pc}, {1'b1, hold_pc});
    end
    out_ready = 1'b1; cycle(r);
    chk("stall_release", {r, out_pc, out_rd}, {1'b1, hold_pc + 32'd4, 5'd9});
    put(1'b0, 32'h0, 1'b1); cycle(r);

    // Flush coincident with an accepted beq
    put(1'b1, 32'h00208463, 1'b1); flush = 1'b1; cycle(r);
    chk("flush_consumed", r, 1'b1);
    chk("flush_valid", out_valid, 1'b0);
    put(1'b0, 32'h0, 1'b1); cycle(r);
    chk("flush_never", out_valid, 1'b0);
    put(1'b1, 32'h00208463, 1'b1); cycle(r);
    chk("beq_imm", {out_imm, out_alu_source}, {32'd8, 1'b0});

    // Reset asserted mid-stall
    put(1'b1, 32'h0000A283, 1'b1); cycle(r);
    put(1'b1, 32'h00100413, 1'b0); cycle(r);
    rst = 1'b1;
    #1;
    chk("midrst_ready", in_ready, 1'b0);
    chk("midrst_valid", {out_valid, out_pc}, 33'd0);
    m_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    put(1'b1, 32'h002101B3, 1'b1); cycle(r);
    chk("midrst_regs", out_rs1_value, 32'h0);

    // Randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      logic [31:0] ins;
      ins = ($urandom() & 32'hFE007000) | (32'($urandom_range(0, 7)) << 20)
            | (32'($urandom_range(0, 7)) << 15) | (32'($urandom_range(0, 7)) << 7)
            | 32'(ops[$urandom_range(0, 11)]);
      put($urandom_range(0, 3) != 0, ins, $urandom_range(0, 3) != 0);
      flush    = ($urandom_range(0, 15) == 0);
      wb_en    = $urandom_range(0, 1) == 1;
      wb_rd    = 5'($urandom_range(0, 9));
      wb_value = $urandom();
      cycle(r);
    end
    put(1'b0, 32'h0, 1'b1); cycle(r);

    // NREG=16 instance: out-of-range indices
    n_wb_en = 1'b1; n_wb_rd = 5'd20; n_wb_value = 32'hDEAD;
    n_in_valid = 1'b1; n_instr = 32'h000A0093;
    @(posedge clk); #1;
    chk("n16_x20_valid", n_out_valid, 1'b1);
    chk("n16_x20_illegal", n_illegal, 1'b1);
    chk("n16_x20_operand", n_rs1_value, 32'h0);
    n_wb_en = 1'b0; n_instr = 32'h004202B3;
    @(posedge clk); #1;
    chk("n16_add_illegal", n_illegal, 1'b0);
    chk("n16_write_ignored", {n_rs1_value, n_rs2_value}, 64'd0);
    n_wb_en = 1'b1; n_wb_rd = 5'd4; n_wb_value = 32'h77; n_instr = 32'h00100893;
    @(posedge clk); #1;
    chk("n16_rd17_illegal", n_illegal, 1'b1);
    n_wb_en = 1'b0; n_instr = 32'h004202B3;
    @(posedge clk); #1;
    chk("n16_x4_read", n_rs1_value, 32'h77);
    n_in_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
